// File: rtl/dev_bus_pkg.sv
// Shared types and constants for the CPU-to-device bus controller.
package dev_bus_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [DATA_W-1:0] ERR_PATTERN = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    // Channel index width; never zero so a single-channel build still has a select bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dev_addr_decode.sv
// Combinational address decoder: the lowest-numbered matching window wins.
module dev_addr_decode
    import dev_bus_pkg::*;
#(
    parameter int                         NUM_CH  = 6,
    parameter int                         IDX_W   = idx_width(NUM_CH),
    parameter logic [NUM_CH*ADDR_W-1:0]   CH_BASE = '0,
    parameter logic [NUM_CH*ADDR_W-1:0]   CH_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  sel
);

    logic [NUM_CH-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_match
            assign match[gi] = ((addr & CH_MASK[gi*ADDR_W +: ADDR_W]) == CH_BASE[gi*ADDR_W +: ADDR_W]);
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit = |match;
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dev_bus_ctrl.sv
// CPU-side bus controller: decodes a request to one device channel, waits for it
// to complete or time out, and reports read data or a bus error.
module dev_bus_ctrl
    import dev_bus_pkg::*;
#(
    parameter int                      NUM_CH  = 6,
    parameter logic [NUM_CH*32-1:0]    CH_BASE = '0,
    parameter logic [NUM_CH*32-1:0]    CH_MASK = '0,
    parameter int                      TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     devEnable_i,
    input  logic                     devWrite_i,
    input  logic [ADDR_W-1:0]        devPhysicalAddr_i,
    input  logic [DATA_W-1:0]        devDataSave_i,
    input  logic [3:0]               devByteSelect_i,
    output logic                     devBusy_o,
    output logic [DATA_W-1:0]        devDataLoad_o,
    output logic                     devError_o,
    output logic [NUM_CH-1:0]        chEnable_o,
    output logic                     chWrite_o,
    output logic [ADDR_W-1:0]        chAddr_o,
    output logic [DATA_W-1:0]        chDataSave_o,
    output logic [3:0]               chByteSelect_o,
    input  logic [NUM_CH*DATA_W-1:0] chDataLoad_i,
    input  logic [NUM_CH-1:0]        chBusy_i
);

    localparam int               IDX_W    = idx_width(NUM_CH);
    localparam int               CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   sel_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               write_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [3:0]         be_reg;
    logic [DATA_W-1:0]  load_reg;

    logic               dec_hit;
    logic [IDX_W-1:0]   dec_sel;
    logic               sel_busy;
    logic [DATA_W-1:0]  sel_load;
    logic [NUM_CH-1:0]  sel_onehot;

    dev_addr_decode #(
        .NUM_CH  (NUM_CH),
        .IDX_W   (IDX_W),
        .CH_BASE (CH_BASE),
        .CH_MASK (CH_MASK)
    ) u_decode (
        .addr (devPhysicalAddr_i),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    assign sel_busy = chBusy_i[sel_reg];
    assign sel_load = chDataLoad_i[sel_reg*DATA_W +: DATA_W];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
            assign sel_onehot[gi] = (sel_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Busy release is tested before the timeout so completion wins a tie.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (devEnable_i) begin
                    state_next = dec_hit ? ST_ACCESS : ST_ERR;
                end
            end
            ST_ACCESS: begin
                if (!sel_busy) begin
                    state_next = ST_DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_ERR;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        devBusy_o  = 1'b0;
        devError_o = 1'b0;
        chEnable_o = '0;
        case (state_reg)
            ST_IDLE:   devBusy_o = devEnable_i;
            ST_ACCESS: begin
                devBusy_o  = 1'b1;
                chEnable_o = sel_onehot;
            end
            ST_ERR:    devError_o = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg   <= '0;
            cnt_reg   <= '0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            be_reg    <= '0;
            load_reg  <= '0;
        end else begin
            if (state_reg == ST_IDLE && devEnable_i) begin
                sel_reg   <= dec_sel;
                write_reg <= devWrite_i;
                addr_reg  <= devPhysicalAddr_i;
                data_reg  <= devDataSave_i;
                be_reg    <= devByteSelect_i;
            end
            cnt_reg <= (state_reg == ST_ACCESS) ? cnt_reg + 1'b1 : '0;
            if (state_next == ST_ERR) begin
                load_reg <= ERR_PATTERN;
            end else if (state_reg == ST_ACCESS && state_next == ST_DONE && !write_reg) begin
                load_reg <= sel_load;
            end
        end
    end

    assign devDataLoad_o  = load_reg;
    assign chWrite_o      = write_reg;
    assign chAddr_o       = addr_reg;
    assign chDataSave_o   = data_reg;
    assign chByteSelect_o = be_reg;

endmodule

// File: tb/tb_dev_bus_ctrl.sv
// Randomized bench for dev_bus_ctrl against a transaction-level outcome model.
module tb_dev_bus_ctrl;

    localparam int NCH = 3;
    localparam int TMO = 4;
    localparam logic [NCH*32-1:0] BASES = {32'h1000_8000, 32'h1FD0_03F8, 32'h1000_0000};
    localparam logic [NCH*32-1:0] MASKS = {32'hFFFF_8000, 32'hFFFF_FFF8, 32'hFFFF_0000};

    logic              clk = 1'b0;
    logic              rst;
    logic              devEnable_i;
    logic              devWrite_i;
    logic [31:0]       devPhysicalAddr_i;
    logic [31:0]       devDataSave_i;
    logic [3:0]        devByteSelect_i;
    logic              devBusy_o;
    logic [31:0]       devDataLoad_o;
    logic              devError_o;
    logic [NCH-1:0]    chEnable_o;
    logic              chWrite_o;
    logic [31:0]       chAddr_o;
    logic [31:0]       chDataSave_o;
    logic [3:0]        chByteSelect_o;
    logic [NCH*32-1:0] chDataLoad_i;
    logic [NCH-1:0]    chBusy_i;

    dev_bus_ctrl #(
        .NUM_CH  (NCH),
        .CH_BASE (BASES),
        .CH_MASK (MASKS),
        .TIMEOUT (TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .devEnable_i       (devEnable_i),
        .devWrite_i        (devWrite_i),
        .devPhysicalAddr_i (devPhysicalAddr_i),
        .devDataSave_i     (devDataSave_i),
        .devByteSelect_i   (devByteSelect_i),
        .devBusy_o         (devBusy_o),
        .devDataLoad_o     (devDataLoad_o),
        .devError_o        (devError_o),
        .chEnable_o        (chEnable_o),
        .chWrite_o         (chWrite_o),
        .chAddr_o          (chAddr_o),
        .chDataSave_o      (chDataSave_o),
        .chByteSelect_o    (chByteSelect_o),
        .chDataLoad_i      (chDataLoad_i),
        .chBusy_i          (chBusy_i)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;
    logic [31:0] win_base [NCH];
    logic [31:0] win_mask [NCH];
    logic [31:0] exp_load;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NCH; i++) begin
            if ((a & win_mask[i]) == win_base[i]) return i;
        end
        return -1;
    endfunction

    // Starts and ends at the falling edge of an IDLE cycle.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] be, input logic [31:0] sel_data,
                          input int busy_len, input bit hold_en);
        int             sel;
        int             n_acc;
        bit             expect_err;
        logic [NCH-1:0] exp_en;
        sel = model_decode(a);
        if (sel < 0) begin
            n_acc = 0;
            expect_err = 1'b1;
        end else if (busy_len >= TMO) begin
            n_acc = TMO;
            expect_err = 1'b1;
        end else begin
            n_acc = busy_len + 1;
            expect_err = 1'b0;
        end
        exp_en = '0;
        if (sel >= 0) exp_en[sel] = 1'b1;

        devEnable_i       = 1'b1;
        devWrite_i        = w;
        devPhysicalAddr_i = a;
        devDataSave_i     = d;
        devByteSelect_i   = be;
        for (int i = 0; i < NCH; i++) chDataLoad_i[i*32 +: 32] = (i == sel) ? sel_data : $urandom;
        chBusy_i = NCH'($urandom);
        #1;
        check_eq("busy_req", 32'(devBusy_o), 32'd1);

        for (int k = 1; k <= n_acc + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            devWrite_i        = 1'($urandom);
            devPhysicalAddr_i = $urandom;
            devDataSave_i     = $urandom;
            devByteSelect_i   = 4'($urandom);
            chBusy_i          = NCH'($urandom);
            if (sel >= 0) chBusy_i[sel] = (k <= busy_len);
            for (int i = 0; i < NCH; i++) begin
                if (i != sel) chDataLoad_i[i*32 +: 32] = $urandom;
            end
            if (k == n_acc + 1 && !hold_en) devEnable_i = 1'b0;
            #1;
            if (k <= n_acc) begin
                check_eq("busy_acc", 32'(devBusy_o), 32'd1);
                check_eq("en_acc", 32'(chEnable_o), 32'(exp_en));
                check_eq("err_acc", 32'(devError_o), 32'd0);
                check_eq("load_hold", devDataLoad_o, exp_load);
            end else begin
                if (expect_err) exp_load = 32'hFFFF_FFFF;
                else if (!w) exp_load = sel_data;
                check_eq("busy_end", 32'(devBusy_o), 32'd0);
                check_eq("en_end", 32'(chEnable_o), 32'd0);
                check_eq("err_end", 32'(devError_o), 32'(expect_err));
                check_eq("load_end", devDataLoad_o, exp_load);
            end
            check_eq("ch_addr", chAddr_o, a);
            check_eq("ch_data", chDataSave_o, d);
            check_eq("ch_write", 32'(chWrite_o), 32'(w));
            check_eq("ch_be", 32'(chByteSelect_o), 32'(be));
        end

        @(posedge clk);
        @(negedge clk);
        if (!hold_en) begin
            #1;
            check_eq("busy_idle", 32'(devBusy_o), 32'd0);
        end
        n_txn++;
        $display("txn %0d addr=%h w=%0d sel=%0d busy_len=%0d -> %s load=%h",
                 n_txn, a, w, sel, busy_len, expect_err ? "ERR" : "DONE", exp_load);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return 32'h1000_0000 | {16'h0, r[15:0]};
            1:       return 32'h1FD0_03F8 | {29'h0, r[2:0]};
            2:       return 32'h1000_8000 | {17'h0, r[14:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < NCH; i++) begin
            win_base[i] = BASES[i*32 +: 32];
            win_mask[i] = MASKS[i*32 +: 32];
        end
        rst               = 1'b1;
        devEnable_i       = 1'b0;
        devWrite_i        = 1'b0;
        devPhysicalAddr_i = '0;
        devDataSave_i     = '0;
        devByteSelect_i   = '0;
        chDataLoad_i      = '0;
        chBusy_i          = '0;
        exp_load          = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_en", 32'(chEnable_o), 32'd0);
        check_eq("rst_err", 32'(devError_o), 32'd0);
        check_eq("rst_load", devDataLoad_o, 32'd0);
        check_eq("rst_addr", chAddr_o, 32'd0);
        check_eq("rst_data", chDataSave_o, 32'd0);
        check_eq("rst_be", 32'(chByteSelect_o), 32'd0);
        check_eq("rst_write", 32'(chWrite_o), 32'd0);
        check_eq("rst_busy0", 32'(devBusy_o), 32'd0);
        devEnable_i = 1'b1;
        #1;
        check_eq("rst_busy1", 32'(devBusy_o), 32'd1);
        devEnable_i = 1'b0;
        rst = 1'b0;

        // Directed cases: fast read, long write, unmapped, timeout edge, overlap.
        do_txn(32'h1FD0_03F8, 1'b0, 32'h1234_5678, 4'hF, 32'h0000_0041, 0, 1'b0);
        do_txn(32'h1000_0040, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h5555_AAAA, 5, 1'b0);
        do_txn(32'hFFFF_0000, 1'b0, 32'h0, 4'h3, 32'h0, 0, 1'b0);
        do_txn(32'h1FD0_03FC, 1'b0, 32'h0, 4'h1, 32'hCAFE_0001, TMO, 1'b0);
        do_txn(32'h1FD0_03FC, 1'b0, 32'h0, 4'h1, 32'hCAFE_0002, TMO - 1, 1'b1);
        do_txn(32'h1000_9000, 1'b0, 32'h0, 4'hC, 32'hBEEF_0003, 1, 1'b1);
        do_txn(32'h1000_A004, 1'b1, 32'h7777_0000, 4'h8, 32'h0, 2, 1'b0);

        // Reset while a channel holds the access open.
        devEnable_i       = 1'b1;
        devWrite_i        = 1'b0;
        devPhysicalAddr_i = 32'h1FD0_03F9;
        @(posedge clk);
        @(negedge clk);
        devEnable_i = 1'b0;
        chBusy_i    = '1;
        #1;
        check_eq("mid_en", 32'(chEnable_o), 32'b010);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_load = '0;
        #1;
        check_eq("mid_rst_en", 32'(chEnable_o), 32'd0);
        check_eq("mid_rst_err", 32'(devError_o), 32'd0);
        check_eq("mid_rst_busy", 32'(devBusy_o), 32'd0);
        check_eq("mid_rst_addr", chAddr_o, 32'd0);
        check_eq("mid_rst_load", devDataLoad_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("post_rst_err", 32'(devError_o), 32'd0);
        check_eq("post_rst_en", 32'(chEnable_o), 32'd0);

        for (int t = 0; t < 200; t++) begin
            bit hold;
            hold = (($urandom % 4) == 0);
            do_txn(rand_addr(), 1'($urandom), $urandom, 4'($urandom), $urandom,
                   $urandom_range(0, TMO + 2), hold);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    @(negedge clk);
                    check_eq("gap_busy", 32'(devBusy_o), 32'd0);
                    check_eq("gap_en", 32'(chEnable_o), 32'd0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
